// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

    // A bubble in IF/ID carries this encoding.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Defaults. IMEM_SIZE_DEF must match the instruction-memory size macro value.
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int unsigned IMEM_SIZE_DEF = 128;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of instruction-memory, hazard-control and IF/ID signals around the fetch controller.
// Latency: n/a (wiring only).
// Backpressure: Stall from the hazard unit holds the fetch stage.
interface if_fetch_ctrl_if;

    // Instruction-memory side
    logic [31:0] InstrAddr;
    logic [31:0] Instr;

    // Hazard / control side
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectAddr;

    // IF/ID pipeline register
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPC;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;

    // Status
    logic        Fault;
    logic [31:0] FaultAddr;
    logic [31:0] FetchCount;

    // The fetch controller
    modport master (
        output InstrAddr,
        input  Instr,
        input  Stall,
        input  Flush,
        input  Redirect,
        input  RedirectAddr,
        output IfIdInstr,
        output IfIdPC,
        output IfIdPCPlus4,
        output IfIdValid,
        output Fault,
        output FaultAddr,
        output FetchCount
    );

    // Memory, hazard unit and decode stage around it
    modport slave (
        input  InstrAddr,
        output Instr,
        output Stall,
        output Flush,
        output Redirect,
        output RedirectAddr,
        input  IfIdInstr,
        input  IfIdPC,
        input  IfIdPCPlus4,
        input  IfIdValid,
        input  Fault,
        input  FaultAddr,
        input  FetchCount
    );

endinterface

// File: rtl/if_addr_check.sv
// Fetch-address legality: word aligned and within the instruction memory.
// Latency: combinational.
// Backpressure: none.
module if_addr_check #(
    parameter int unsigned IMEM_SIZE = 128
) (
    input  logic [31:0] pc,
    output logic        legal
);

    // Highest word-aligned address that still fits a full 4-byte read.
    localparam logic [31:0] MAX_PC = 32'(IMEM_SIZE - 4);

    // Full-width unsigned compare, so high addresses can never alias into range.
    assign legal = (pc[1:0] == 2'b00) && (pc <= MAX_PC);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, drives imem address, fills IF/ID, traps illegal fetches.
// Latency: word at PC lands in IF/ID one edge later (imem is combinational, no wait states).
// Backpressure: Stall holds PC and IF/ID; Redirect overrides Stall/Flush; FAULT halts until reset.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned IMEM_SIZE = IMEM_SIZE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    if_fetch_ctrl_if.master bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic         ifid_vld_q, ifid_vld_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_addr_q, fault_addr_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;

    logic         pc_legal;
    logic [31:0]  pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    if_addr_check #(
        .IMEM_SIZE (IMEM_SIZE)
    ) u_addr_check (
        .pc    (pc_q),
        .legal (pc_legal)
    );

    // State and IF/ID registers; reset throws away anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_vld_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            fetch_cnt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Next-state: redirect > stall+flush > stall > flush > fetch > fault trap.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fetch_cnt_d  = fetch_cnt_q;

        unique case (state_q)
            RUN: begin
                if (bus.Redirect) begin
                    // Current fetch is wrong-path, so an illegal PC here is not a fault.
                    pc_d         = bus.RedirectAddr;
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end else if (bus.Stall && bus.Flush) begin
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end else if (bus.Stall) begin
                    // Hold everything.
                end else if (bus.Flush) begin
                    pc_d         = pc_plus4;
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end else if (pc_legal) begin
                    pc_d         = pc_plus4;
                    ifid_instr_d = bus.Instr;
                    ifid_pc_d    = pc_q;
                    ifid_pc4_d   = pc_plus4;
                    ifid_vld_d   = 1'b1;
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                end else begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    fault_addr_d = pc_q;
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end
            FAULT: begin
                // Front end is dead until reset; keep IF/ID a bubble.
                ifid_vld_d   = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.InstrAddr   = pc_q;
    assign bus.IfIdInstr   = ifid_instr_q;
    assign bus.IfIdPC      = ifid_pc_q;
    assign bus.IfIdPCPlus4 = ifid_pc4_q;
    assign bus.IfIdValid   = ifid_vld_q;
    assign bus.Fault       = fault_q;
    assign bus.FaultAddr   = fault_addr_q;
    assign bus.FetchCount  = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a scoreboard of expected IF/ID entries.
// Latency: checks one edge after each stimulus step (#1 after the rising edge).
// Backpressure: exercises Stall, Flush, Redirect and the sticky fault state.
module tb_if_fetch_ctrl;
    import if_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } sb_t;

    logic clk;
    logic rst_n;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(
        .RESET_PC  (32'h0),
        .IMEM_SIZE (128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model state
    logic [31:0] pc_m;
    logic        st_f;
    logic [31:0] cnt_m;
    logic [31:0] faddr_m;
    logic [31:0] h_instr, h_pc, h_pc4;
    logic        h_vld;
    logic        m_legal;
    sb_t         sb_q[$];

    int n_chk;
    int n_err;

    logic [7:0] mem [128];

    if_addr_check #(.IMEM_SIZE(128)) u_ref_check (
        .pc    (pc_m),
        .legal (m_legal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct bytes per position so a byte-order error is visible.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {8'hE0, lo, 8'h5A, ~lo};
    endfunction

    // Big-endian combinational instruction memory; reads past the end return zero.
    always_comb begin
        bus.Instr = 32'h0;
        if (bus.InstrAddr <= 32'd124)
            bus.Instr = {mem[bus.InstrAddr[6:0]],        mem[bus.InstrAddr[6:0] + 7'd1],
                         mem[bus.InstrAddr[6:0] + 7'd2], mem[bus.InstrAddr[6:0] + 7'd3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("InstrAddr",   bus.InstrAddr,          pc_m);
        chk("IfIdValid",   32'(bus.IfIdValid),     32'(h_vld));
        chk("IfIdInstr",   bus.IfIdInstr,          h_instr);
        chk("IfIdPC",      bus.IfIdPC,             h_pc);
        chk("IfIdPCPlus4", bus.IfIdPCPlus4,        h_pc4);
        chk("Fault",       32'(bus.Fault),         32'(st_f));
        chk("FaultAddr",   bus.FaultAddr,          faddr_m);
        chk("FetchCount",  bus.FetchCount,         cnt_m);
    endtask

    task automatic model_reset();
        pc_m    = 32'h0;
        st_f    = 1'b0;
        cnt_m   = 32'h0;
        faddr_m = 32'h0;
        h_instr = 32'h0;
        h_pc    = 32'h0;
        h_pc4   = 32'h0;
        h_vld   = 1'b0;
        sb_q.delete();
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] ra);
        bus.Stall        = s;
        bus.Flush        = f;
        bus.Redirect     = r;
        bus.RedirectAddr = ra;
    endtask

    // Called from a check point (#1 after an edge); finishes well before the next edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        #2;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus: predict, push expected entries, clock, pop and compare.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] ra);
        logic acc;
        logic bub;
        sb_t  e;
        acc = 1'b0;
        bub = 1'b0;
        drive(s, f, r, ra);
        if (!st_f) begin
            if (r) begin
                pc_m = ra;
                bub  = 1'b1;
            end else if (s && f) begin
                bub = 1'b1;
            end else if (s) begin
                bub = 1'b0;
            end else if (f) begin
                pc_m = pc_m + 32'd4;
                bub  = 1'b1;
            end else if (m_legal) begin
                sb_q.push_back('{exp_word(pc_m), pc_m, pc_m + 32'd4});
                pc_m  = pc_m + 32'd4;
                cnt_m = cnt_m + 32'd1;
                acc   = 1'b1;
            end else begin
                st_f    = 1'b1;
                faddr_m = pc_m;
                bub     = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            e       = sb_q.pop_front();
            h_instr = e.instr;
            h_pc    = e.pc;
            h_pc4   = e.pc4;
            h_vld   = 1'b1;
        end else if (bub) begin
            h_instr = 32'h0;
            h_vld   = 1'b0;
        end
        check_model();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int a = 0; a < 128; a += 4) begin
            logic [31:0] w;
            w = exp_word(32'(a));
            mem[a]     = w[31:24];
            mem[a + 1] = w[23:16];
            mem[a + 2] = w[15:8];
            mem[a + 3] = w[7:0];
        end
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();

        // Reset values
        #12;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: 0, 4 captured; then stall twice at PC=8
        step(0, 0, 0, 0);
        chk("first_valid", 32'(bus.IfIdValid), 32'd1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("stall_pc",  bus.InstrAddr,  32'h8);
        chk("stall_ifid", bus.IfIdPC,    32'h4);
        chk("stall_cnt", bus.FetchCount, 32'd2);
        step(0, 0, 0, 0);
        chk("after_stall_pc",    bus.IfIdPC,     32'h8);
        chk("after_stall_instr", bus.IfIdInstr,  32'hE008_5AF7);
        chk("cnt3",              bus.FetchCount, 32'd3);

        // Redirect wins over Stall at PC=0x10
        step(0, 0, 0, 0);
        step(1, 0, 1, 32'h40);
        chk("redir_pc",  bus.InstrAddr,        32'h40);
        chk("redir_vld", 32'(bus.IfIdValid),   32'd0);
        step(0, 0, 0, 0);
        chk("redir_ifid", bus.IfIdPC,          32'h40);

        // Flush alone, then stall+flush
        step(0, 1, 0, 0);
        chk("flush_cnt", bus.FetchCount, 32'd5);
        chk("flush_pc",  bus.InstrAddr,  32'h48);
        step(1, 1, 0, 0);
        chk("sf_pc",     bus.InstrAddr,  32'h48);

        // Run up to the last word, redirect at illegal PC does not fault
        step(0, 0, 1, 32'h70);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("last_word", bus.IfIdPC, 32'h7C);
        step(0, 0, 1, 32'h20);
        chk("redir_no_fault", 32'(bus.Fault), 32'd0);
        chk("redir_no_fault_pc", bus.InstrAddr, 32'h20);

        // Fetch past the end traps; fault is sticky
        step(0, 0, 1, 32'h7C);
        step(0, 0, 0, 0);
        chk("word_7c", bus.IfIdInstr, 32'hE07C_5A83);
        step(0, 0, 0, 0);
        chk("fault_end",      32'(bus.Fault), 32'd1);
        chk("fault_end_addr", bus.FaultAddr,  32'h80);
        step(0, 0, 1, 32'h0);
        step(0, 0, 0, 0);
        chk("fault_frozen_pc", bus.InstrAddr, 32'h80);

        // Misaligned redirect target faults at the next unstalled edge
        do_reset();
        step(0, 0, 1, 32'h6);
        step(1, 0, 0, 0);
        chk("mis_stalled", 32'(bus.Fault), 32'd0);
        step(0, 0, 0, 0);
        chk("mis_fault",      32'(bus.Fault), 32'd1);
        chk("mis_fault_addr", bus.FaultAddr,  32'h6);

        // Asynchronous reset mid-cycle while stalled at 0x20
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("pre_rst_pc", bus.InstrAddr, 32'h20);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("async_rst_pc", bus.InstrAddr, 32'h0);
        #2;
        rst_n = 1'b1;
        drive(0, 0, 0, 0);

        // High address must not alias into range
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("hi_fault_addr", bus.FaultAddr, 32'hFFFF_FFFC);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
